// File: rtl/score_keeper_if.sv
// score_keeper_if: game-input and score-output bundle between game logic and the score keeper
interface score_keeper_if;
  logic i_frame_tick;
  logic i_move;
  logic i_collision;
  logic i_restart;
  logic [7:0] o_score;
  logic [7:0] o_high_score;
  logic o_game_over;
  logic o_new_high;
  modport master(output i_frame_tick, i_move, i_collision, i_restart, input o_score, o_high_score, o_game_over, o_new_high);
  modport slave(input i_frame_tick, i_move, i_collision, i_restart, output o_score, o_high_score, o_game_over, o_new_high);
endinterface

// File: rtl/score_keeper.sv
// score_keeper: frame-synchronous game state and score counter; SCORE_KEEPER_HIGH_SCORE_EN adds a session high score
module score_keeper #(
  parameter int STEP_FRAMES = 8,
  parameter int SCORE_MAX = 255
) (
  input logic i_clk,
  input logic i_rst,
  score_keeper_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  localparam logic [7:0] LAST = 8'(STEP_FRAMES - 1);
  localparam logic [7:0] TOP = 8'(SCORE_MAX);
  state_t state, state_n;
  logic [7:0] score, score_n, cnt, cnt_n;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      score <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      score <= score_n;
      cnt <= cnt_n;
    end
  // score only moves on frame ticks so the renderer never sees a mid-frame change
  always_comb begin
    state_n = state;
    score_n = score;
    cnt_n = cnt;
    if (bus.i_restart) begin
      state_n = IDLE;
      score_n = '0;
      cnt_n = '0;
    end else if (state == IDLE) begin
      state_n = (bus.i_frame_tick && bus.i_move) ? RUN : IDLE;
    end else if (state == RUN) begin
      if (bus.i_collision) state_n = OVER;
      else if (bus.i_frame_tick) begin
        cnt_n = (bus.i_move && cnt != LAST) ? cnt + 8'd1 : '0;
        score_n = (bus.i_move && cnt == LAST && score != TOP) ? score + 8'd1 : score;
      end
    end
  end
  assign bus.o_score = score;
  assign bus.o_game_over = state == OVER;
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic [7:0] high;
  logic new_high, beat;
  assign beat = !bus.i_restart && state == RUN && bus.i_collision && score > high;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      high <= '0;
      new_high <= 1'b0;
    end else begin
      new_high <= beat;
      high <= beat ? score : high;
    end
  assign bus.o_high_score = high;
  assign bus.o_new_high = new_high;
`else
  assign bus.o_high_score = '0;
  assign bus.o_new_high = 1'b0;
`endif
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: two parameterisations driven identically, checked every cycle against a game-rule model
module tb_score_keeper;
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  score_keeper_if ifa();
  score_keeper_if ifb();
  score_keeper dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
  score_keeper #(.STEP_FRAMES(1), .SCORE_MAX(5)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));
  int total = 0, bad = 0;
  int stepp[2] = '{8, 1};
  int smx[2] = '{255, 5};
  int st[2], streak[2], sc[2], hi[2], nh[2];
  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // game rules: streak = consecutive held ticks since start or release; score on every STEP-th
  task automatic model(bit r, bit t, bit m, bit c, bit s);
    for (int d = 0; d < 2; d++) begin
      nh[d] = 0;
      if (r) begin
        st[d] = 0; streak[d] = 0; sc[d] = 0; hi[d] = 0;
      end else if (s) begin
        st[d] = 0; streak[d] = 0; sc[d] = 0;
      end else if (st[d] == 0) begin
        if (t && m) begin st[d] = 1; streak[d] = 0; end
      end else if (st[d] == 1) begin
        if (c) begin
          st[d] = 2;
          if (EN && sc[d] > hi[d]) begin hi[d] = sc[d]; nh[d] = 1; end
        end else if (t) begin
          if (!m) streak[d] = 0;
          else begin
            streak[d]++;
            if (streak[d] % stepp[d] == 0 && sc[d] < smx[d]) sc[d]++;
          end
        end
      end
    end
  endtask
  task automatic cyc(bit r, bit t, bit m, bit c, bit s);
    rst = r;
    ifa.i_frame_tick = t; ifa.i_move = m; ifa.i_collision = c; ifa.i_restart = s;
    ifb.i_frame_tick = t; ifb.i_move = m; ifb.i_collision = c; ifb.i_restart = s;
    @(posedge clk);
    model(r, t, m, c, s);
    #1;
    chk("a_score", int'(ifa.o_score), sc[0]);
    chk("a_over", int'(ifa.o_game_over), int'(st[0] == 2));
    chk("a_high", int'(ifa.o_high_score), hi[0]);
    chk("a_newhi", int'(ifa.o_new_high), nh[0]);
    chk("b_score", int'(ifb.o_score), sc[1]);
    chk("b_over", int'(ifb.o_game_over), int'(st[1] == 2));
    chk("b_high", int'(ifb.o_high_score), hi[1]);
    chk("b_newhi", int'(ifb.o_new_high), nh[1]);
  endtask
  task automatic ticks(int n, bit m);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, m, 0, 0);
      cyc(0, 0, m, 0, 0);
    end
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    ticks(5, 0);
    chk("idle_score", int'(ifa.o_score), 0);
    ticks(25, 1);
    chk("held25", int'(ifa.o_score), 3);
    chk("sat5", int'(ifb.o_score), 5);
    cyc(0, 0, 0, 0, 1);
    ticks(11, 1);
    ticks(1, 0);
    ticks(13, 1);
    cyc(0, 0, 0, 0, 1);
    ticks(5, 1);
    cyc(0, 0, 0, 1, 0);
    chk("go_over", int'(ifb.o_game_over), 1);
    chk("go_high", int'(ifb.o_high_score), EN ? 4 : 0);
    chk("go_newhi", int'(ifb.o_new_high), EN ? 1 : 0);
    ticks(3, 1);
    chk("over_hold", int'(ifb.o_score), 4);
    cyc(0, 0, 0, 0, 1);
    ticks(5, 1);
    cyc(0, 0, 0, 1, 0);
    chk("eq_no_newhi", int'(ifb.o_new_high), 0);
    cyc(0, 0, 0, 0, 1);
    ticks(3, 1);
    cyc(0, 1, 1, 1, 0);
    chk("coll_tick", int'(ifb.o_score), 2);
    cyc(0, 0, 0, 0, 1);
    ticks(2, 1);
    cyc(0, 0, 0, 1, 1);
    chk("rst_coll_over", int'(ifb.o_game_over), 0);
    chk("rst_coll_high", int'(ifb.o_high_score), EN ? 4 : 0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 8,
          $urandom_range(0, 59) == 0, $urandom_range(0, 79) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
